// File: rtl/imem_readback.sv
// imem_readback
//   Instruction-memory readback engine. On a start command it reads a
//   contiguous range of instruction-memory words and streams each one out
//   as a 7-byte frame {zero pad, address, data}, most significant byte first.
//   This is the same byte format the imem loader shifts in, so a dump can be
//   replayed directly as a load.
//
// Ports
//   clk            core clock, all state changes on the rising edge
//   reset          synchronous, active-high
//   start          command strobe, only looked at while idle
//   start_adr      first word address, captured with start
//   word_count     number of words minus one, captured with start
//   imem_read      read enable to instruction memory
//   imem_read_adr  read address
//   imem_out       read data, valid the cycle after imem_read
//   byte_out       current frame byte
//   byte_valid     byte_out holds a byte
//   byte_ready     consumer accepts the byte this cycle
//   busy           engine is not idle
//   done           one-cycle pulse after the last byte of the range
module imem_readback #(
  parameter int ADR_WIDTH  = 10,
  parameter int DATA_WIDTH = 40   // ADR_WIDTH + DATA_WIDTH must not exceed 56
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADR_WIDTH-1:0]  start_adr,
  input  logic [ADR_WIDTH-1:0]  word_count,
  output logic                  imem_read,
  output logic [ADR_WIDTH-1:0]  imem_read_adr,
  input  logic [DATA_WIDTH-1:0] imem_out,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int FRAME_WIDTH = 56;
  localparam int FRAME_BYTES = FRAME_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t                 state_reg, state_next;
  logic [ADR_WIDTH-1:0]   adr_reg, adr_next;
  logic [ADR_WIDTH-1:0]   remain_reg, remain_next;
  logic [FRAME_WIDTH-1:0] frame_reg, frame_next;
  logic [2:0]             byte_cnt_reg, byte_cnt_next;
  logic                   done_reg, done_next;
  logic [FRAME_WIDTH-1:0] frame_load;

  // Assemble {pad, address, data} bit by bit so a zero-width pad field
  // (ADR_WIDTH + DATA_WIDTH == 56) still elaborates cleanly.
  generate
    for (genvar gi = 0; gi < FRAME_WIDTH; gi++) begin : g_frame
      if (gi < DATA_WIDTH) begin : g_data
        assign frame_load[gi] = imem_out[gi];
      end else if (gi < DATA_WIDTH + ADR_WIDTH) begin : g_adr
        assign frame_load[gi] = adr_reg[gi-DATA_WIDTH];
      end else begin : g_pad
        assign frame_load[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      adr_reg      <= '0;
      remain_reg   <= '0;
      frame_reg    <= '0;
      byte_cnt_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      adr_reg      <= adr_next;
      remain_reg   <= remain_next;
      frame_reg    <= frame_next;
      byte_cnt_reg <= byte_cnt_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    adr_next      = adr_reg;
    remain_next   = remain_reg;
    frame_next    = frame_reg;
    byte_cnt_next = byte_cnt_reg;
    done_next     = 1'b0;
    imem_read     = 1'b0;
    byte_valid    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          adr_next    = start_adr;
          remain_next = word_count;
          state_next  = S_READ;
        end
      end

      S_READ: begin
        imem_read  = 1'b1;
        state_next = S_CAPTURE;
      end

      // Read data arrives this cycle; latch it together with its address.
      S_CAPTURE: begin
        frame_next    = frame_load;
        byte_cnt_next = '0;
        state_next    = S_SEND;
      end

      S_SEND: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          // Shifting left leaves the frame all-zero after the last byte,
          // so byte_out reads 0 again once the engine is idle.
          frame_next    = frame_reg << 8;
          byte_cnt_next = byte_cnt_reg + 3'd1;
          if (byte_cnt_reg == 3'(FRAME_BYTES - 1)) begin
            if (remain_reg == '0) begin
              done_next  = 1'b1;
              state_next = S_IDLE;
            end else begin
              remain_next = remain_reg - ADR_WIDTH'(1);
              adr_next    = adr_reg + ADR_WIDTH'(1);   // wraps modulo 2^ADR_WIDTH
              state_next  = S_READ;
            end
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign imem_read_adr = adr_reg;
  assign byte_out      = frame_reg[FRAME_WIDTH-1 -: 8];
  assign busy          = (state_reg != S_IDLE);
  assign done          = done_reg;

endmodule

// File: tb/tb_imem_readback.sv
module tb_imem_readback;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] start_adr;
  logic [9:0] word_count;
  logic       imem_read;
  logic [9:0] imem_read_adr;
  logic [39:0] imem_out;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  imem_readback #(.ADR_WIDTH(10), .DATA_WIDTH(40)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_adr     (start_adr),
    .word_count    (word_count),
    .imem_read     (imem_read),
    .imem_read_adr (imem_read_adr),
    .imem_out      (imem_out),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .busy          (busy),
    .done          (done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit bp_en = 1'b0;

  logic [39:0] mem [0:1023];
  logic [39:0] img [0:1023];

  // Everything the monitor observed, in order
  logic [7:0] byte_q[$];
  int         acc_cyc_q[$];
  logic [9:0] rd_q[$];
  int         rd_cyc_q[$];
  int         done_cyc_q[$];
  int         stall_err = 0;
  int         busy_done_err = 0;
  bit         hold_pending = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with registered read
  always @(posedge clk) if (imem_read) imem_out <= mem[imem_read_adr];

  // Consumer ready: always high, or ~30% random duty when bp_en is set
  initial begin
    byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      byte_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor samples mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (imem_read) begin
        rd_q.push_back(imem_read_adr);
        rd_cyc_q.push_back(cyc);
      end
      if (byte_valid && byte_ready) begin
        byte_q.push_back(byte_out);
        acc_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (done && busy) busy_done_err++;
      if (hold_pending && (!byte_valid || byte_out !== hold_byte)) stall_err++;
      hold_pending = byte_valid && !byte_ready;
      hold_byte    = byte_out;
    end
  end

  function automatic logic [7:0] exp_byte(input logic [9:0] a, input logic [39:0] d, input int i);
    logic [55:0] f;
    f = {6'b0, a, d};
    return f[55-8*i -: 8];
  endfunction

  function automatic logic [7:0] got_byte(input int idx);
    return (idx < byte_q.size()) ? byte_q[idx] : 8'hxx;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise start for one cycle; t0 is the cycle in which start is sampled
  task automatic launch(input logic [9:0] a, input logic [9:0] wc, output int t0);
    start      = 1'b1;
    start_adr  = a;
    word_count = wc;
    t0         = cyc;
    step(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (done_cyc_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(3);
    @(negedge clk);
    n_vec++; if (imem_read !== 1'b0) begin n_err++; $display("FAIL reset_imem_read: got %b want 0", imem_read); end
    n_vec++; if (imem_read_adr !== 10'h000) begin n_err++; $display("FAIL reset_imem_read_adr: got %h want 000", imem_read_adr); end
    n_vec++; if (byte_out !== 8'h00) begin n_err++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(2);
    $display("test_reset: done");
  endtask

  task automatic test_single_word;
    int t0, b0, r0, d0, bd0;
    bit ok;
    logic [7:0] exp_b [0:6];
    exp_b = '{8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    mem[10'h005] = 40'h12_3456_789A;
    b0 = byte_q.size(); r0 = rd_q.size(); d0 = done_cyc_q.size(); bd0 = busy_done_err;
    launch(10'h005, 10'h000, t0);
    wait_done(d0 + 1, 200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_done_timeout: got no done want done"); end
    n_vec++; if (byte_q.size() - b0 != 7) begin n_err++; $display("FAIL single_byte_count: got %0d want 7", byte_q.size() - b0); end
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (got_byte(b0 + i) !== exp_b[i]) begin n_err++; $display("FAIL single_byte%0d: got %h want %h", i, got_byte(b0 + i), exp_b[i]); end
    end
    n_vec++; if (rd_q.size() - r0 != 1) begin n_err++; $display("FAIL single_read_count: got %0d want 1", rd_q.size() - r0); end
    if (rd_q.size() > r0) begin
      n_vec++; if (rd_q[r0] !== 10'h005) begin n_err++; $display("FAIL single_read_adr: got %h want 005", rd_q[r0]); end
      n_vec++; if (rd_cyc_q[r0] - t0 != 1) begin n_err++; $display("FAIL single_read_cycle: got %0d want 1", rd_cyc_q[r0] - t0); end
    end
    if (acc_cyc_q.size() > b0) begin
      n_vec++; if (acc_cyc_q[b0] - t0 != 3) begin n_err++; $display("FAIL single_first_byte_cycle: got %0d want 3", acc_cyc_q[b0] - t0); end
    end
    if (done_cyc_q.size() > d0) begin
      n_vec++; if (done_cyc_q[d0] - t0 != 10) begin n_err++; $display("FAIL single_done_cycle: got %0d want 10", done_cyc_q[d0] - t0); end
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse_width: got %b want 0", done); end
    n_vec++; if (busy_done_err != bd0) begin n_err++; $display("FAIL single_busy_in_done: got %0d want %0d", busy_done_err, bd0); end
    step(5);
    n_vec++; if (done_cyc_q.size() - d0 != 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", done_cyc_q.size() - d0); end
    $display("test_single_word: %0d bytes, done at +%0d", byte_q.size() - b0, ok ? done_cyc_q[d0] - t0 : -1);
  endtask

  task automatic test_wrap;
    int t0, b0, r0, d0;
    bit ok;
    logic [7:0] exp_b [0:13];
    exp_b = '{8'h03, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
              8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    mem[10'h3FF] = 40'hAA_BBCC_DDEE;
    mem[10'h000] = 40'h01_0203_0405;
    b0 = byte_q.size(); r0 = rd_q.size(); d0 = done_cyc_q.size();
    launch(10'h3FF, 10'h001, t0);
    wait_done(d0 + 1, 300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_done_timeout: got no done want done"); end
    for (int i = 0; i < 14; i++) begin
      n_vec++;
      if (got_byte(b0 + i) !== exp_b[i]) begin n_err++; $display("FAIL wrap_byte%0d: got %h want %h", i, got_byte(b0 + i), exp_b[i]); end
    end
    n_vec++; if (rd_q.size() - r0 != 2) begin n_err++; $display("FAIL wrap_read_count: got %0d want 2", rd_q.size() - r0); end
    if (rd_q.size() - r0 >= 2) begin
      n_vec++; if (rd_q[r0] !== 10'h3FF) begin n_err++; $display("FAIL wrap_read_adr0: got %h want 3ff", rd_q[r0]); end
      n_vec++; if (rd_q[r0+1] !== 10'h000) begin n_err++; $display("FAIL wrap_read_adr1: got %h want 000", rd_q[r0+1]); end
    end
    if (done_cyc_q.size() > d0) begin
      n_vec++; if (done_cyc_q[d0] - t0 != 19) begin n_err++; $display("FAIL wrap_done_cycle: got %0d want 19", done_cyc_q[d0] - t0); end
    end
    step(5);
    n_vec++; if (done_cyc_q.size() - d0 != 1) begin n_err++; $display("FAIL wrap_done_count: got %0d want 1", done_cyc_q.size() - d0); end
    $display("test_wrap: %0d bytes, %0d reads", byte_q.size() - b0, rd_q.size() - r0);
  endtask

  task automatic test_backpressure;
    int t0, b0, d0, s0;
    bit ok;
    mem[10'h100] = 40'hF0_E1D2_C3B4;
    mem[10'h101] = 40'h00_1122_3344;
    mem[10'h102] = 40'hFF_FFFF_FFFF;
    mem[10'h103] = 40'h5A_A55A_A55A;
    for (int pass = 0; pass < 2; pass++) begin
      bp_en = (pass == 1);
      b0 = byte_q.size(); d0 = done_cyc_q.size(); s0 = stall_err;
      launch(10'h100, 10'h003, t0);
      wait_done(d0 + 1, 2000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL bp%0d_done_timeout: got no done want done", pass); end
      n_vec++; if (byte_q.size() - b0 != 28) begin n_err++; $display("FAIL bp%0d_byte_count: got %0d want 28", pass, byte_q.size() - b0); end
      for (int w = 0; w < 4; w++) begin
        for (int i = 0; i < 7; i++) begin
          logic [9:0] a;
          logic [7:0] e;
          a = 10'h100 + 10'(w);
          e = exp_byte(a, mem[a], i);
          n_vec++;
          if (got_byte(b0 + 7*w + i) !== e) begin n_err++; $display("FAIL bp%0d_w%0d_byte%0d: got %h want %h", pass, w, i, got_byte(b0 + 7*w + i), e); end
        end
      end
      n_vec++; if (stall_err != s0) begin n_err++; $display("FAIL bp%0d_stall_stability: got %0d changes want 0", pass, stall_err - s0); end
      bp_en = 1'b0;
      step(3);
      $display("test_backpressure: pass %0d, %0d bytes in %0d cycles", pass, byte_q.size() - b0, ok ? done_cyc_q[d0] - t0 : -1);
    end
  endtask

  task automatic test_start_while_busy;
    int t0, tb, b0, r0, d0;
    bit ok;
    logic [9:0] adrs [0:2];
    adrs = '{10'h200, 10'h201, 10'h010};
    mem[10'h200] = 40'h11_2233_4455;
    mem[10'h201] = 40'h66_7788_99AA;
    mem[10'h010] = 40'hC0_FFEE_BABE;
    mem[10'h300] = 40'hDE_ADBE_EF00;
    b0 = byte_q.size(); r0 = rd_q.size(); d0 = done_cyc_q.size();
    launch(10'h200, 10'h001, t0);
    step(4);                         // cycle 5: mid-frame of word 0
    start = 1'b1; start_adr = 10'h300; word_count = 10'h000;
    step(1);
    start = 1'b0; start_adr = 10'h000; word_count = 10'h005;
    step(13);                        // cycle 19: the done cycle of range A
    start = 1'b1; start_adr = 10'h010; word_count = 10'h000;
    tb = cyc;
    step(1);
    start = 1'b0;
    wait_done(d0 + 2, 400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL busy_done_timeout: got %0d dones want 2", done_cyc_q.size() - d0); end
    n_vec++; if (rd_q.size() - r0 != 3) begin n_err++; $display("FAIL busy_read_count: got %0d want 3", rd_q.size() - r0); end
    for (int k = 0; k < 3; k++) begin
      if (rd_q.size() > r0 + k) begin
        n_vec++; if (rd_q[r0+k] !== adrs[k]) begin n_err++; $display("FAIL busy_read_adr%0d: got %h want %h", k, rd_q[r0+k], adrs[k]); end
      end
    end
    if (rd_q.size() > r0 + 2) begin
      n_vec++; if (rd_cyc_q[r0+2] - tb != 1) begin n_err++; $display("FAIL busy_b2b_read_cycle: got %0d want 1", rd_cyc_q[r0+2] - tb); end
    end
    if (done_cyc_q.size() >= d0 + 2) begin
      n_vec++; if (done_cyc_q[d0] - t0 != 19) begin n_err++; $display("FAIL busy_doneA_cycle: got %0d want 19", done_cyc_q[d0] - t0); end
      n_vec++; if (done_cyc_q[d0+1] - t0 != 29) begin n_err++; $display("FAIL busy_doneB_cycle: got %0d want 29", done_cyc_q[d0+1] - t0); end
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        logic [7:0] e;
        e = exp_byte(adrs[k], mem[adrs[k]], i);
        n_vec++;
        if (got_byte(b0 + 7*k + i) !== e) begin n_err++; $display("FAIL busy_w%0d_byte%0d: got %h want %h", k, i, got_byte(b0 + 7*k + i), e); end
      end
    end
    step(3);
    $display("test_start_while_busy: %0d reads, %0d bytes", rd_q.size() - r0, byte_q.size() - b0);
  endtask

  task automatic test_reset_mid;
    int t0, b0, d0;
    bit ok;
    for (int w = 0; w < 4; w++) mem[10'h020 + 10'(w)] = 40'h30_0000_0000 + 40'(w);
    mem[10'h040] = 40'h87_6543_210F;
    mem[10'h041] = 40'h0F_1E2D_3C4B;
    b0 = byte_q.size(); d0 = done_cyc_q.size();
    launch(10'h020, 10'h003, t0);
    step(14);                        // cycle 15: 3rd byte of word 2 just accepted
    n_vec++; if (byte_q.size() - b0 != 10) begin n_err++; $display("FAIL rstmid_bytes_before: got %0d want 10", byte_q.size() - b0); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_read !== 1'b0) begin n_err++; $display("FAIL rstmid_imem_read: got %b want 0", imem_read); end
    n_vec++; if (imem_read_adr !== 10'h000) begin n_err++; $display("FAIL rstmid_imem_read_adr: got %h want 000", imem_read_adr); end
    n_vec++; if (byte_out !== 8'h00) begin n_err++; $display("FAIL rstmid_byte_out: got %h want 00", byte_out); end
    n_vec++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_byte_valid: got %b want 0", byte_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
    step(20);
    n_vec++; if (done_cyc_q.size() != d0) begin n_err++; $display("FAIL rstmid_no_done: got %0d dones want 0", done_cyc_q.size() - d0); end
    n_vec++; if (byte_q.size() - b0 != 10) begin n_err++; $display("FAIL rstmid_bytes_after: got %0d want 10", byte_q.size() - b0); end
    b0 = byte_q.size();
    launch(10'h040, 10'h001, t0);
    wait_done(d0 + 1, 300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_restart_timeout: got no done want done"); end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 7; i++) begin
        logic [9:0] a;
        logic [7:0] e;
        a = 10'h040 + 10'(w);
        e = exp_byte(a, mem[a], i);
        n_vec++;
        if (got_byte(b0 + 7*w + i) !== e) begin n_err++; $display("FAIL rstmid_w%0d_byte%0d: got %h want %h", w, i, got_byte(b0 + 7*w + i), e); end
      end
    end
    step(3);
    $display("test_reset_mid: restart sent %0d bytes", byte_q.size() - b0);
  endtask

  task automatic test_round_trip;
    int t0, b0, d0;
    bit ok;
    logic [63:0] r;
    logic [55:0] f;
    logic [9:0] a;
    for (int w = 0; w < 16; w++) begin
      a = 10'h3F8 + 10'(w);
      r = {$urandom, $urandom};
      mem[a] = r[39:0] | 40'h1;      // keep every word distinct from the cleared image
      img[a] = 40'h0;
    end
    b0 = byte_q.size(); d0 = done_cyc_q.size();
    bp_en = 1'b1;
    launch(10'h3F8, 10'h00F, t0);
    wait_done(d0 + 1, 4000, ok);
    bp_en = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL rt_done_timeout: got no done want done"); end
    n_vec++; if (byte_q.size() - b0 != 112) begin n_err++; $display("FAIL rt_byte_count: got %0d want 112", byte_q.size() - b0); end
    // Loader model: shift bytes in MSB first, then write the word back
    for (int w = 0; w < 16; w++) begin
      f = '0;
      for (int i = 0; i < 7; i++) f = {f[47:0], got_byte(b0 + 7*w + i)};
      n_vec++; if (f[55:50] !== 6'b0) begin n_err++; $display("FAIL rt_pad%0d: got %h want 00", w, f[55:50]); end
      if (!$isunknown(f[49:40])) img[f[49:40]] = f[39:0];
    end
    for (int w = 0; w < 16; w++) begin
      a = 10'h3F8 + 10'(w);
      n_vec++; if (img[a] !== mem[a]) begin n_err++; $display("FAIL rt_word_%h: got %h want %h", a, img[a], mem[a]); end
    end
    step(3);
    $display("test_round_trip: %0d words reloaded", 16);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 40'h0;
      img[i] = 40'h0;
    end
    reset      = 1'b1;
    start      = 1'b0;
    start_adr  = 10'h000;
    word_count = 10'h000;
    test_reset;
    test_single_word;
    test_wrap;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid;
    test_round_trip;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
